// File: rtl/fifo_out_arbiter_pkg.sv
// Shared types and default sizing for the dual-FIFO output arbiter.
package fifo_out_arbiter_pkg;

    localparam int DEFAULT_DATA_W    = 16;
    localparam int DEFAULT_BURST_LEN = 2;
    localparam int DEFAULT_CNT_W     = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    typedef logic src_t;

    function automatic src_t other_src(input src_t s);
        return ~s;
    endfunction

endpackage

// File: rtl/fifo_out_arbiter_if.sv
// Handshake bundle between the two FIFO sources, the arbiter and the downstream consumer.
interface fifo_out_arbiter_if
    import fifo_out_arbiter_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int CNT_W  = DEFAULT_CNT_W
);
    logic [DATA_W-1:0] data_in0;
    logic              data_in_vld0;
    logic              data_in_rdy0;
    logic [DATA_W-1:0] data_in1;
    logic              data_in_vld1;
    logic              data_in_rdy1;
    logic [DATA_W-1:0] data_out;
    logic              data_out_src;
    logic              data_out_vld;
    logic              data_out_rdy;
    logic [CNT_W-1:0]  beats0;
    logic [CNT_W-1:0]  beats1;

    // Environment side: drives the sources and the downstream ready.
    modport master (
        output data_in0, data_in_vld0, data_in1, data_in_vld1, data_out_rdy,
        input  data_in_rdy0, data_in_rdy1, data_out, data_out_src, data_out_vld,
        input  beats0, beats1
    );

    // Arbiter side.
    modport slave (
        input  data_in0, data_in_vld0, data_in1, data_in_vld1, data_out_rdy,
        output data_in_rdy0, data_in_rdy1, data_out, data_out_src, data_out_vld,
        output beats0, beats1
    );
endinterface

// File: rtl/fifo_out_arbiter_out_reg_stage.sv
// Single-entry registered valid/ready stage carrying {src, data}.
// Latency 1 cycle; accepts a new word only while slot_free, holds contents while stalled.
module fifo_out_arbiter_out_reg_stage #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_vld,
    input  logic [W-1:0] in_dat,
    input  logic         out_rdy,
    output logic         out_vld,
    output logic [W-1:0] out_dat,
    output logic         slot_free
);

    assign slot_free = !out_vld || out_rdy;

    // in_vld is only raised by the arbiter when slot_free is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld <= 1'b0;
            out_dat <= '0;
        end else if (in_vld) begin
            out_vld <= 1'b1;
            out_dat <= in_dat;
        end else if (out_rdy) begin
            out_vld <= 1'b0;
        end
    end

endmodule

// File: rtl/fifo_out_arbiter.sv
// Round-robin burst arbiter merging two 16-bit FIFO streams into one tagged stream.
// Latency 1 cycle (plus one arbitration cycle per grant); a downstream stall freezes the burst without releasing it.
module fifo_out_arbiter
    import fifo_out_arbiter_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int BURST_LEN = DEFAULT_BURST_LEN,
    parameter int CNT_W     = DEFAULT_CNT_W
) (
    input logic               clk,
    input logic               rst,
    fifo_out_arbiter_if.slave bus
);

    localparam int BC_W = $clog2(BURST_LEN + 1);

    arb_state_t      state, state_nxt;
    src_t            grant, grant_nxt;
    src_t            last, last_nxt;
    logic [BC_W-1:0] cnt, cnt_nxt;

    logic            slot_free;
    logic            gnt_vld;
    logic            xfer0, xfer1, xfer;
    logic [DATA_W:0] ld_dat;
    logic [DATA_W:0] out_dat;
    logic            out_vld;

    assign gnt_vld = grant ? bus.data_in_vld1 : bus.data_in_vld0;

    assign bus.data_in_rdy0 = (state == BURST) && (grant == 1'b0) && slot_free;
    assign bus.data_in_rdy1 = (state == BURST) && (grant == 1'b1) && slot_free;

    assign xfer0 = bus.data_in_vld0 && bus.data_in_rdy0;
    assign xfer1 = bus.data_in_vld1 && bus.data_in_rdy1;
    assign xfer  = xfer0 || xfer1;

    assign ld_dat = grant ? {1'b1, bus.data_in1} : {1'b0, bus.data_in0};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            grant <= 1'b0;
            last  <= 1'b1;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            last  <= last_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        last_nxt  = last;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (bus.data_in_vld0 || bus.data_in_vld1) begin
                    state_nxt = BURST;
                    cnt_nxt   = '0;
                    if (bus.data_in_vld0 && bus.data_in_vld1) begin
                        grant_nxt = other_src(last);
                    end else begin
                        grant_nxt = bus.data_in_vld1;
                    end
                end
            end
            BURST: begin
                if (xfer) begin
                    cnt_nxt = cnt + BC_W'(1);
                    if (cnt_nxt == BC_W'(BURST_LEN)) begin
                        last_nxt  = grant;
                        state_nxt = IDLE;
                    end
                // A granted source that goes quiet gives up the rest of its burst,
                // but only once the output slot could have taken a word.
                end else if (slot_free && !gnt_vld) begin
                    last_nxt  = grant;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.beats0 <= '0;
            bus.beats1 <= '0;
        end else begin
            if (xfer0) bus.beats0 <= bus.beats0 + CNT_W'(1);
            if (xfer1) bus.beats1 <= bus.beats1 + CNT_W'(1);
        end
    end

    fifo_out_arbiter_out_reg_stage #(
        .W (DATA_W + 1)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .in_vld    (xfer),
        .in_dat    (ld_dat),
        .out_rdy   (bus.data_out_rdy),
        .out_vld   (out_vld),
        .out_dat   (out_dat),
        .slot_free (slot_free)
    );

    assign bus.data_out     = out_dat[DATA_W-1:0];
    assign bus.data_out_src = out_dat[DATA_W];
    assign bus.data_out_vld = out_vld;

endmodule

// File: tb/tb_fifo_out_arbiter.sv
// Bench for fifo_out_arbiter: per-source word queues feed a scoreboard popped by a negedge monitor,
// with directed timing scenarios and a randomized traffic phase.
module tb_fifo_out_arbiter;

    localparam int DW = 16;
    localparam int BL = 2;
    localparam int CW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_out_arbiter_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

    fifo_out_arbiter #(
        .DATA_W    (DW),
        .BURST_LEN (BL),
        .CNT_W     (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [DW-1:0] sq0[$], sq1[$];      // words still to be offered by each source
    logic [DW-1:0] eq0[$], eq1[$];      // words expected at the output, per source
    logic [DW:0]   out_log[$];
    int            out_cyc[$];
    int            fc0[$], fc1[$];      // cycles of input transfers

    bit en0 = 1'b0, en1 = 1'b0, out_rdy = 1'b1, rand_rdy = 1'b0;
    bit fire0 = 1'b0, fire1 = 1'b0;
    bit rst_d = 1'b1, p_fire = 1'b0, p_stall = 1'b0;
    logic [DW:0]   p_word = '0, p_out = '0;
    logic [CW-1:0] mb0 = '0, mb1 = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic int qat(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    function automatic logic [DW:0] logat(input int i);
        return (i < out_log.size()) ? out_log[i] : 'x;
    endfunction

    function automatic void clear_all();
        sq0.delete(); sq1.delete(); eq0.delete(); eq1.delete();
        out_log.delete(); out_cyc.delete(); fc0.delete(); fc1.delete();
    endfunction

    task automatic push0(input logic [DW-1:0] w);
        sq0.push_back(w); eq0.push_back(w);
    endtask

    task automatic push1(input logic [DW-1:0] w);
        sq1.push_back(w); eq1.push_back(w);
    endtask

    // Apply inputs for the coming cycle, then advance past the next posedge.
    task automatic step();
        bus.data_in_vld0 = en0 && (sq0.size() > 0);
        bus.data_in0     = (sq0.size() > 0) ? sq0[0] : '0;
        bus.data_in_vld1 = en1 && (sq1.size() > 0);
        bus.data_in1     = (sq1.size() > 0) ? sq1[0] : '0;
        bus.data_out_rdy = rand_rdy ? ($urandom_range(0, 99) < 70) : out_rdy;
        @(posedge clk);
        #1;
        if (fire0) void'(sq0.pop_front());
        if (fire1) void'(sq1.pop_front());
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1; en0 = 1'b0; en1 = 1'b0;
        repeat (n) step();
        rst = 1'b0;
        clear_all();
    endtask

    always @(negedge clk) begin
        cyc++;
        if (rst_d) begin
            mb0 = '0;
            mb1 = '0;
            chk("rst_out_vld", 64'(bus.data_out_vld), 64'(0));
            chk("rst_data_out", 64'(bus.data_out), 64'(0));
            chk("rst_out_src", 64'(bus.data_out_src), 64'(0));
            chk("rst_rdy", 64'({bus.data_in_rdy1, bus.data_in_rdy0}), 64'(0));
            chk("rst_beats", 64'({bus.beats1, bus.beats0}), 64'(0));
        end else begin
            chk("beats0", 64'(bus.beats0), 64'(mb0));
            chk("beats1", 64'(bus.beats1), 64'(mb1));
            chk("one_rdy", 64'(bus.data_in_rdy0 && bus.data_in_rdy1), 64'(0));
            if (bus.data_out_vld && !bus.data_out_rdy)
                chk("stall_rdy", 64'(bus.data_in_rdy0 || bus.data_in_rdy1), 64'(0));
            if (p_fire)
                chk("latency", 64'({bus.data_out_vld, bus.data_out_src, bus.data_out}), 64'({1'b1, p_word}));
            else if (p_stall)
                chk("hold", 64'({bus.data_out_vld, bus.data_out_src, bus.data_out}), 64'({1'b1, p_out}));
            if (bus.data_out_vld && bus.data_out_rdy && !rst) begin
                out_log.push_back({bus.data_out_src, bus.data_out});
                out_cyc.push_back(cyc);
                if (bus.data_out_src == 1'b0) begin
                    chk("sb0_pending", 64'(eq0.size() > 0), 64'(1));
                    if (eq0.size() > 0) chk("sb0_data", 64'(bus.data_out), 64'(eq0.pop_front()));
                end else begin
                    chk("sb1_pending", 64'(eq1.size() > 0), 64'(1));
                    if (eq1.size() > 0) chk("sb1_data", 64'(bus.data_out), 64'(eq1.pop_front()));
                end
            end
        end
        fire0 = !rst && bus.data_in_vld0 && bus.data_in_rdy0;
        fire1 = !rst && bus.data_in_vld1 && bus.data_in_rdy1;
        if (fire0) begin mb0 = mb0 + CW'(1); fc0.push_back(cyc); end
        if (fire1) begin mb1 = mb1 + CW'(1); fc1.push_back(cyc); end
        p_fire  = fire0 || fire1;
        p_word  = fire1 ? {1'b1, bus.data_in1} : {1'b0, bus.data_in0};
        p_stall = !rst && bus.data_out_vld && !bus.data_out_rdy;
        p_out   = {bus.data_out_src, bus.data_out};
        rst_d   = rst;
    end

    initial begin
        int b;
        int pushed0, pushed1, n;
        logic [DW-1:0] w;

        bus.data_in0 = '0; bus.data_in_vld0 = 1'b0;
        bus.data_in1 = '0; bus.data_in_vld1 = 1'b0;
        bus.data_out_rdy = 1'b1;

        // Reset then idle
        do_reset(2);
        repeat (3) begin
            step();
            chk("idle_out_vld", 64'(bus.data_out_vld), 64'(0));
            chk("idle_rdy", 64'({bus.data_in_rdy1, bus.data_in_rdy0}), 64'(0));
            chk("idle_beats", 64'({bus.beats1, bus.beats0}), 64'(0));
        end

        // Single source: one arbitration cycle, then two transfers, each visible one cycle later
        push0(16'h1111); push0(16'h2222);
        en0 = 1'b1; out_rdy = 1'b1;
        b = cyc;
        repeat (6) step();
        chk("ss_fire_a", 64'(qat(fc0, 0)), 64'(b + 2));
        chk("ss_fire_b", 64'(qat(fc0, 1)), 64'(b + 3));
        chk("ss_out_cyc_a", 64'(qat(out_cyc, 0)), 64'(b + 3));
        chk("ss_out_cyc_b", 64'(qat(out_cyc, 1)), 64'(b + 4));
        chk("ss_out_a", 64'(logat(0)), 64'({1'b0, 16'h1111}));
        chk("ss_out_b", 64'(logat(1)), 64'({1'b0, 16'h2222}));
        chk("ss_beats0", 64'(bus.beats0), 64'(2));

        // Contention: BL words per grant, alternating, one bubble per grant
        do_reset(1);
        for (int i = 0; i < 8; i++) begin
            push0(16'hA000 + 16'(i));
            push1(16'hB000 + 16'(i));
        end
        en0 = 1'b1; en1 = 1'b1;
        b = cyc;
        repeat (16) step();
        for (int k = 0; k < 6; k++) begin
            int blk, g, idx;
            blk = k / BL;
            g   = blk % 2;
            idx = (blk / 2) * BL + k % BL;
            chk($sformatf("cont_word%0d", k), 64'(logat(k)),
                64'({1'(g), (g == 1 ? 16'hB000 : 16'hA000) + 16'(idx)}));
            chk($sformatf("cont_cyc%0d", k), 64'(qat(out_cyc, k)), 64'(b + 3 + blk * (BL + 1) + k % BL));
        end

        // Backpressure for 5 cycles right after the first word of a burst
        do_reset(1);
        for (int i = 0; i < 4; i++) begin
            push0(16'hC000 + 16'(i));
            push1(16'hD000 + 16'(i));
        end
        en0 = 1'b1; en1 = 1'b1;
        b = cyc;
        step(); step();
        out_rdy = 1'b0;
        repeat (5) step();
        out_rdy = 1'b1;
        repeat (12) step();
        chk("bp_fire_a0", 64'(qat(fc0, 0)), 64'(b + 2));
        chk("bp_fire_a1", 64'(qat(fc0, 1)), 64'(b + 8));
        chk("bp_out_cyc0", 64'(qat(out_cyc, 0)), 64'(b + 8));
        chk("bp_fire_b0", 64'(qat(fc1, 0)), 64'(b + 10));
        chk("bp_order", 64'({logat(0), logat(1), logat(2), logat(3)}),
            64'({17'h0C000, 17'h0C001, 17'h1D000, 17'h1D001}));

        // Early release: source 1 offers a single word while source 0 waits
        do_reset(1);
        push1(16'hE000);
        push0(16'hF000); push0(16'hF001);
        en1 = 1'b1; en0 = 1'b0;
        b = cyc;
        step();
        en0 = 1'b1;
        repeat (10) step();
        chk("er_fires1", 64'(fc1.size()), 64'(1));
        chk("er_fire_b", 64'(qat(fc1, 0)), 64'(b + 2));
        chk("er_fire_a0", 64'(qat(fc0, 0)), 64'(b + 5));
        chk("er_fire_a1", 64'(qat(fc0, 1)), 64'(b + 6));
        chk("er_order", 64'({logat(0), logat(1), logat(2)}), 64'({17'h1E000, 17'h0F000, 17'h0F001}));

        // Reset in the middle of a source-0 burst
        do_reset(1);
        push0(16'h3000); push0(16'h3001); push0(16'h3002);
        push1(16'h4000); push1(16'h4001);
        en0 = 1'b1; en1 = 1'b1;
        step(); step();
        chk("mr_pre_vld", 64'(bus.data_out_vld), 64'(1));
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mr_out_vld", 64'(bus.data_out_vld), 64'(0));
        chk("mr_beats", 64'({bus.beats1, bus.beats0}), 64'(0));
        clear_all();
        push0(16'h1000); push0(16'h1001);
        push1(16'h2000); push1(16'h2001);
        b = cyc;
        repeat (10) step();
        chk("mr_first_out", 64'(logat(0)), 64'({1'b0, 16'h1000}));
        chk("mr_fire_a", 64'(qat(fc0, 0)), 64'(b + 2));
        chk("mr_fire_b", 64'(qat(fc1, 0)), 64'(b + 5));

        // Randomized traffic with random downstream stalls and source gaps
        do_reset(1);
        pushed0 = 0; pushed1 = 0;
        rand_rdy = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (sq0.size() < 4 && $urandom_range(0, 2) == 0) begin
                w = 16'($urandom); push0(w); pushed0++;
            end
            if (sq1.size() < 4 && $urandom_range(0, 2) == 0) begin
                w = 16'($urandom); push1(w); pushed1++;
            end
            en0 = ($urandom_range(0, 3) != 0);
            en1 = ($urandom_range(0, 3) != 0);
            step();
        end
        rand_rdy = 1'b0; out_rdy = 1'b1; en0 = 1'b1; en1 = 1'b1;
        n = 0;
        while ((eq0.size() > 0 || eq1.size() > 0) && n < 500) begin
            step();
            n++;
        end
        chk("rand_drain0", 64'(eq0.size()), 64'(0));
        chk("rand_drain1", 64'(eq1.size()), 64'(0));
        chk("rand_beats0", 64'(bus.beats0), 64'(pushed0));
        chk("rand_beats1", 64'(bus.beats1), 64'(pushed1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_out_arbiter.md
Name: fifo_out_arbiter

Overview:
- Round-robin burst arbiter that merges the two 16-bit output streams of the dual FIFO into one valid/ready stream.
- Each word carries a source tag.
- A granted source holds the output for up to BURST_LEN words, so consecutive halves of a 32-bit input word stay adjacent.
- Output is registered by a single-entry pipeline stage. Sits between the dual FIFO and the downstream 16-bit consumer.

Parameters:
- DATA_W, 16, data width of every stream
- BURST_LEN, 2, maximum words transferred per grant (>=1)
- CNT_W, 32, width of the per-source beat counters

Ports:
- clk  input  1  clock, all logic on posedge
- rst  input  1  synchronous active-high reset
- data_in0  input  DATA_W  source 0 data
- data_in_vld0  input  1  source 0 valid
- data_in_rdy0  output  1  source 0 ready
- data_in1  input  DATA_W  source 1 data
- data_in_vld1  input  1  source 1 valid
- data_in_rdy1  output  1  source 1 ready
- data_out  output  DATA_W  merged data (registered)
- data_out_src  output  1  source index of data_out
- data_out_vld  output  1  merged valid (registered)
- data_out_rdy  input  1  downstream ready
- beats0  output  CNT_W  words forwarded from source 0, wraps
- beats1  output  CNT_W  words forwarded from source 1, wraps

Behaviour:
- Reset: one clock; reset is synchronous and active-high.
  - Outputs: data_out_vld=0, data_out=0, data_out_src=0, beats0=beats1=0, data_in_rdy0/1=0.
  - Internal: state=IDLE, last=1 (so source 0 has first priority), burst count=0.
  - Reset mid-burst discards the output register content and any burst in progress.
- Output stage: slot_free = !data_out_vld || data_out_rdy.
- Transfer on input i = data_in_vld_i && data_in_rdy_i.
  - On a transfer the word, with src=i, is loaded into the output register. Latency is exactly 1 cycle.
  - Otherwise, if data_out_rdy is high, data_out_vld clears.
  - data_out and data_out_src hold while data_out_vld && !data_out_rdy.
- data_in_rdy_i = (state==BURST) && (grant==i) && slot_free. The non-granted source always sees rdy=0.
- State machine:
  - IDLE:
    - No requests: stay in IDLE.
    - One requester: grant it.
    - Both requesting: grant the source != last.
    - Any grant moves to BURST with cnt=0. This costs one arbitration cycle with no transfer.
  - BURST:
    - Each transfer increments cnt.
    - The cycle where cnt reaches BURST_LEN: set last=grant, go to IDLE.
    - Early release: when slot_free && !data_in_vld_grant, set last=grant, go to IDLE (the burst is released with no transfer).
    - Downstream stall (slot_free=0) never releases the grant.
- Counters: beats_i increments on each transfer from source i. They wrap modulo 2^CNT_W with no saturation.
- Fairness: with both sources continuously valid and downstream always ready, the output pattern is BURST_LEN words from 0, then BURST_LEN words from 1, and so on. Throughput is BURST_LEN/(BURST_LEN+1).
- Data words are never dropped or duplicated. Order within each source is preserved.

Decomposition:
- Shared package: arbiter state enum (IDLE, BURST), src index typedef, default DATA_W/BURST_LEN constants.
- One natural sub-module: out_reg_stage (single-entry valid/ready register carrying {src, data}). Arbitration FSM and counters stay in the top.

Test Plan:
- Reset then idle:
  - Stimulus: rst high 2 cycles, vld0=vld1=0.
  - Required: data_out_vld=0, rdy0=rdy1=0, beats0=beats1=0 throughout.
- Single source:
  - Stimulus: source 0 offers 0x1111, 0x2222 back-to-back, data_out_rdy=1, BURST_LEN=2.
  - Required: IDLE cycle, transfers on the next 2 cycles, each appearing 1 cycle later with src=0; then beats0=2.
- Contention:
  - Stimulus: both sources continuously valid (src0 0xA000+n, src1 0xB000+n), data_out_rdy=1.
  - Required: output sequence A000, A001, B000, B001, A002, A003; exactly one bubble per grant.
- Backpressure:
  - Stimulus: data_out_rdy=0 for 5 cycles mid-burst.
  - Required: data_out/src stable, rdy of granted source=0, no grant change. After release, burst resumes and data completes in order.
- Early release:
  - Stimulus: source 1 valid for 1 word only while source 0 waiting, BURST_LEN=2.
  - Required: src1 word forwarded, grant released the next free-slot cycle, then source 0 granted.
- Reset mid-burst:
  - Stimulus: rst asserted while data_out_vld=1 and cnt=1.
  - Required: next cycle data_out_vld=0, beats cleared, first post-reset grant goes to source 0.
